cycle_sequencer: RTL

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

---
 rtl/cycle_sequencer_if.sv | 31 +++
 rtl/cycle_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/cycle_sequencer_if.sv
// Handshake and control bundle between the instruction sequencer and its datapath/memory.
interface cycle_sequencer_if;
  logic       run;
  logic [7:0] instr;
  logic       mem_ack;
  logic       acc_zero;
  logic       mem_req;
  logic       mem_we;
  logic       mem_sel_pc;
  logic       ir_load;
  logic       pc_inc;
  logic       pc_load;
  logic [2:0] aluop;
  logic [1:0] accdst;
  logic       accwrite;
  logic       illegal;
  logic       err;
  logic [2:0] state;

  modport master (
    input  run, instr, mem_ack, acc_zero,
    output mem_req, mem_we, mem_sel_pc, ir_load, pc_inc, pc_load,
    output aluop, accdst, accwrite, illegal, err, state
  );

  modport slave (
    output run, instr, mem_ack, acc_zero,
    input  mem_req, mem_we, mem_sel_pc, ir_load, pc_inc, pc_load,
    input  aluop, accdst, accwrite, illegal, err, state
  );
endinterface

// File: rtl/cycle_sequencer.sv
// Multi-cycle fetch/decode/mem/writeback sequencer, 2-4 cycles per instruction plus memory waits;
// stalls in FETCH/MEM until mem_ack. CYCLE_SEQ_TIMEOUT_EN adds a 255-cycle memory timeout (err).
module cycle_sequencer (
  input  logic              clk,
  input  logic              rst,
  cycle_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    FETCH  = 3'b001,
    DECODE = 3'b010,
    MEM    = 3'b011,
    WB     = 3'b100,
    BRANCH = 3'b101
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_JUMP  = 4'h1;
  localparam logic [3:0] OP_SAVE  = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_SLL   = 4'h4;
  localparam logic [3:0] OP_LOADI = 4'h5;
  localparam logic [3:0] OP_BZ    = 4'hF;

  state_t     state;
  logic [3:0] ir_op;
  logic       is_alu;
  logic       is_undef;
  logic       timeout;
  logic       unused_operand;

  // Operand nibble is consumed by the datapath, not by sequencing.
  assign unused_operand = ^bus.instr[3:0];

  assign is_alu   = ir_op[3] && (ir_op != OP_BZ) && (ir_op != 4'hD);
  assign is_undef = (ir_op == 4'h6) || (ir_op == 4'h7) || (ir_op == 4'hD);

  function automatic state_t end_state(input logic go);
    return go ? FETCH : IDLE;
  endfunction

`ifdef CYCLE_SEQ_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       waiting;

  assign waiting = ((state == FETCH) || (state == MEM)) && !bus.mem_ack;
  assign timeout = waiting && (wait_cnt == 8'hFF);

  // Any exit from FETCH/MEM is an ack or a timeout, both of which clear the count.
  always_ff @(posedge clk) begin
    if (rst)
      wait_cnt <= '0;
    else if (waiting && !timeout)
      wait_cnt <= wait_cnt + 8'd1;
    else
      wait_cnt <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ir_op <= '0;
    end else begin
      case (state)
        IDLE:    if (bus.run) state <= FETCH;
        FETCH: begin
          if (bus.mem_ack) begin
            ir_op <= bus.instr[7:4];
            state <= DECODE;
          end else if (timeout) begin
            state <= IDLE;
          end
        end
        DECODE: begin
          case (ir_op)
            OP_NOP:            state <= end_state(bus.run);
            OP_SLL, OP_LOADI:  state <= WB;
            OP_JUMP, OP_BZ:    state <= BRANCH;
            OP_SAVE, OP_LOAD:  state <= MEM;
            default:           state <= is_alu ? MEM : end_state(bus.run);
          endcase
        end
        MEM: begin
          if (bus.mem_ack)
            state <= (ir_op == OP_SAVE) ? end_state(bus.run) : WB;
          else if (timeout)
            state <= IDLE;
        end
        WB, BRANCH: state <= end_state(bus.run);
        default:    state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_sel_pc = 1'b0;
    bus.ir_load    = 1'b0;
    bus.pc_inc     = 1'b0;
    bus.pc_load    = 1'b0;
    bus.accdst     = 2'b00;
    bus.accwrite   = 1'b0;
    bus.illegal    = 1'b0;
    case (state)
      FETCH: begin
        bus.mem_req    = 1'b1;
        bus.mem_sel_pc = 1'b1;
        bus.ir_load    = bus.mem_ack;
        bus.pc_inc     = bus.mem_ack;
      end
      DECODE: bus.illegal = is_undef;
      MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = (ir_op == OP_SAVE);
      end
      WB: begin
        bus.accwrite = 1'b1;
        case (ir_op)
          OP_LOAD:  bus.accdst = 2'b00;
          OP_LOADI: bus.accdst = 2'b01;
          OP_SLL:   bus.accdst = 2'b11;
          default:  bus.accdst = 2'b10;
        endcase
      end
      BRANCH: bus.pc_load = (ir_op == OP_JUMP) || ((ir_op == OP_BZ) && bus.acc_zero);
      default: ;
    endcase
  end

  assign bus.aluop = (((state == MEM) || (state == WB)) && is_alu) ? ir_op[2:0] : 3'b000;
  assign bus.err   = timeout;
  assign bus.state = state;

endmodule
